nlfsr_period_checker: RTL and testbench

- Parametrised successor to the single-width NLFSR full-period checker.
- Loads a run-time seed and steps a SIZE-bit right-shifting NLFSR; the nonlinear feedback function lives outside the block.
- Reports whether the trajectory returns to the seed with full period 2^SIZE-1, returns early, or never returns. Also reports the measured period length.
- Sits between the feedback-function selector and the result collector. Runs are started and acknowledged by a start/done handshake.

---
 rtl/nlfsr_pkg.sv | 20 ++
 rtl/nlfsr_core.sv | 36 +++
 rtl/nlfsr_period_checker.sv | 128 ++++++++++++
 tb/tb_nlfsr_period_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlfsr_pkg.sv
// Shared types and helpers for the NLFSR full-period checker.
package nlfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Length of a maximal trajectory for a size-bit register: 2^size - 1.
  function automatic logic [63:0] full_period(input int size);
    return (64'd1 << size) - 64'd1;
  endfunction

  // Reset / idle register value: MSB set, all other bits clear.
  function automatic logic [31:0] init_val(input int size);
    return 32'd1 << (size - 1);
  endfunction

endpackage

// File: rtl/nlfsr_core.sv
// SIZE-bit right-shifting NLFSR register. The nonlinear feedback term is
// supplied from outside; the core only combines it with the LSB.
module nlfsr_core
  import nlfsr_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            res,
  input  logic            load,
  input  logic            step,
  input  logic [SIZE-1:0] load_val,
  input  logic            feedback,
  output logic [SIZE-1:0] state,
  output logic [SIZE-1:0] nxt
);

  localparam logic [SIZE-1:0] INIT = SIZE'(init_val(SIZE));

  // Next state: feedback XOR the outgoing bit enters at the MSB.
  always_comb begin
    nxt = {feedback ^ state[0], state[SIZE-1:1]};
  end

  // Register: load takes priority over a step; otherwise hold.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= INIT;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/nlfsr_period_checker.sv
// Runs the NLFSR from a seed and classifies the trajectory: full period,
// early return to the seed, or no return within 2^SIZE steps.
module nlfsr_period_checker
  import nlfsr_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int CNT_W = SIZE + 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic             ena,
  input  logic [SIZE-1:0]  seed,
  input  logic             feedback,
  output logic [SIZE-1:0]  state,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             failure,
  output logic [CNT_W-1:0] period_out
);

  localparam logic [SIZE-1:0]  INIT  = SIZE'(init_val(SIZE));
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(full_period(SIZE));
  // 2^SIZE fits because CNT_W >= SIZE+1.
  localparam logic [CNT_W-1:0] LIMIT = FULL + CNT_W'(1);

  fsm_t             fsm;
  logic [SIZE-1:0]  seed_reg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SIZE-1:0]  nxt;
  logic             accept;
  logic             step;
  logic             hit_seed;

  // A start is honoured only outside RUN and loses to a simultaneous abort;
  // the core steps only on enabled, non-aborted RUN cycles.
  always_comb begin
    accept   = (fsm != RUN) && start && !abort;
    step     = (fsm == RUN) && ena && !abort;
    cnt_nxt  = cnt + CNT_W'(1);
    hit_seed = (nxt == seed_reg);
  end

  nlfsr_core #(
    .SIZE (SIZE)
  ) u_core (
    .clk      (clk),
    .res      (res),
    .load     (accept),
    .step     (step),
    .load_val (seed),
    .feedback (feedback),
    .state    (state),
    .nxt      (nxt)
  );

  // Control FSM, step counter and registered result flags.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fsm        <= IDLE;
      seed_reg   <= INIT;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      failure    <= 1'b0;
      period_out <= '0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (abort) begin
            fsm        <= IDLE;
            done       <= 1'b0;
            found      <= 1'b0;
            failure    <= 1'b0;
            period_out <= '0;
          end else if (start) begin
            fsm        <= RUN;
            seed_reg   <= seed;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            found      <= 1'b0;
            failure    <= 1'b0;
            period_out <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            fsm  <= IDLE;
            cnt  <= '0;
            busy <= 1'b0;
          end else if (ena) begin
            cnt <= cnt_nxt;
            if (hit_seed) begin
              // Back at the seed: full period only if exactly FULL steps.
              fsm        <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              period_out <= cnt_nxt;
              if (cnt_nxt == FULL) begin
                found <= 1'b1;
              end else begin
                failure <= 1'b1;
              end
            end else if (cnt_nxt == LIMIT) begin
              // Trajectory fell into a cycle that excludes the seed.
              fsm        <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              failure    <= 1'b1;
              period_out <= '0;
            end
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nlfsr_period_checker.sv
// Randomised self-checking bench for nlfsr_period_checker at SIZE=4.
module tb_nlfsr_period_checker;

  localparam int SIZE  = 4;
  localparam int CNT_W = 5;

  logic             clk;
  logic             res;
  logic             start;
  logic             abort;
  logic             ena;
  logic [SIZE-1:0]  seed;
  logic             feedback;
  logic [SIZE-1:0]  state;
  logic             busy;
  logic             done;
  logic             found;
  logic             failure;
  logic [CNT_W-1:0] period_out;

  int checks   = 0;
  int failures = 0;

  // Feedback selection: 0 = state[1], 1 = zero, 2 = state[0], 3 = table.
  int          fb_mode;
  logic [15:0] fb_table;

  nlfsr_period_checker #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .abort      (abort),
    .ena        (ena),
    .seed       (seed),
    .feedback   (feedback),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .failure    (failure),
    .period_out (period_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (fb_mode)
      0:       feedback = state[1];
      1:       feedback = 1'b0;
      2:       feedback = state[0];
      default: feedback = fb_table[state];
    endcase
  end

  // Reference: the successor of an integer state under the chosen feedback.
  function automatic int succ(input int mode, input logic [15:0] tbl, input int s);
    int f;
    case (mode)
      0:       f = (s / 2) % 2;
      1:       f = 0;
      2:       f = s % 2;
      default: f = tbl[s];
    endcase
    return ((f ^ (s % 2)) * 8) + (s / 2);
  endfunction

  // Reference orbit walk: first k in 1..16 with succ^k(seed)==seed, else timeout.
  task automatic model_run(input int sd, output int per, output bit fnd,
                           output bit fl, output int fin);
    int s;
    s = sd;
    per = 0; fnd = 0; fl = 1; fin = 0;
    for (int k = 1; k <= 16; k++) begin
      s = succ(fb_mode, fb_table, s);
      if (s == sd) begin
        per = k;
        fnd = (k == 15);
        fl  = !fnd;
        fin = s;
        return;
      end
    end
    fin = s;
  endtask

  task automatic launch(input logic [SIZE-1:0] sd);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ena_mode: 0 = always high, 1 = 0/1 alternating from 0, 2 = random.
  task automatic run_until_done(input int ena_mode, output int cycles, output int highs);
    cycles = 0;
    highs  = 0;
    while (!done && cycles < 200) begin
      case (ena_mode)
        0:       ena = 1'b1;
        1:       ena = (cycles % 2 == 1);
        default: ena = 1'($urandom_range(0, 1));
      endcase
      if (ena) highs++;
      @(negedge clk);
      cycles++;
    end
    ena = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL run_timeout: done=%0b after %0d cycles, required 1", done, cycles);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 4'b1000 || busy !== 0 || done !== 0 || found !== 0 ||
        failure !== 0 || period_out !== 0) begin
      failures++;
      $display("FAIL reset_values: state=%b busy=%b done=%b found=%b failure=%b period=%0d",
               state, busy, done, found, failure, period_out);
    end
  endtask

  task automatic check_result(input string name, input int sd, input int cycles,
                              input int exp_cycles);
    int per, fin;
    bit fnd, fl;
    model_run(sd, per, fnd, fl, fin);
    checks++;
    if (done !== 1 || found !== fnd || failure !== fl || period_out !== CNT_W'(per) ||
        state !== SIZE'(fin) || busy !== 0) begin
      failures++;
      $display("FAIL %s: done=%b found=%b failure=%b period=%0d state=%b busy=%b; required 1 %b %b %0d %b 0",
               name, done, found, failure, period_out, state, busy, fnd, fl, per, SIZE'(fin));
    end
    checks++;
    if (cycles !== exp_cycles) begin
      failures++;
      $display("FAIL %s_cycles: got %0d required %0d", name, cycles, exp_cycles);
    end
  endtask

  task automatic test_maximal();
    int c, h;
    fb_mode = 0;
    launch(4'b1000);
    checks++;
    if (busy !== 1 || done !== 0) begin
      failures++;
      $display("FAIL maximal_busy: busy=%b done=%b required 1 0", busy, done);
    end
    run_until_done(0, c, h);
    check_result("maximal", 8, c, 15);
  endtask

  task automatic test_rotate();
    int c, h;
    fb_mode = 1;
    launch(4'b1000);
    run_until_done(0, c, h);
    check_result("rotate", 8, c, 4);
  endtask

  task automatic test_drain();
    int c, h;
    fb_mode = 2;
    launch(4'b1000);
    run_until_done(0, c, h);
    check_result("drain_timeout", 8, c, 16);
  endtask

  task automatic test_ena_toggle();
    int c, h;
    fb_mode = 0;
    launch(4'b1000);
    run_until_done(1, c, h);
    check_result("ena_toggle", 8, c, 30);
  endtask

  task automatic test_abort();
    int c, h, s;
    fb_mode = 0;
    launch(4'b1000);
    s = 8;
    ena = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s = succ(fb_mode, fb_table, s);
    end
    ena   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ena   = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0 || found !== 0 || failure !== 0 || state !== SIZE'(s)) begin
      failures++;
      $display("FAIL abort_idle: busy=%b done=%b found=%b failure=%b state=%b; required 0 0 0 0 %b",
               busy, done, found, failure, state, SIZE'(s));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || state !== SIZE'(s)) begin
      failures++;
      $display("FAIL abort_hold: busy=%b state=%b required 0 %b", busy, state, SIZE'(s));
    end
    launch(4'b0011);
    run_until_done(0, c, h);
    check_result("after_abort", 3, c, 15);
  endtask

  task automatic test_start_in_run();
    int c, h;
    fb_mode = 0;
    launch(4'b0101);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    seed  = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_done(0, c, h);
    check_result("start_in_run", 5, c + 4, 15);
  endtask

  task automatic test_start_abort();
    // From DONE (left by the previous test): both high returns to IDLE.
    checks++;
    if (done !== 1) begin
      failures++;
      $display("FAIL pre_done: done=%b required 1", done);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0 || found !== 0 || failure !== 0) begin
      failures++;
      $display("FAIL start_abort_done: busy=%b done=%b found=%b failure=%b required 0 0 0 0",
               busy, done, found, failure);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL start_abort_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int c, h;
    fb_mode = 1;
    launch(4'b1000);
    run_until_done(0, c, h);
    // Re-launch directly from DONE.
    fb_mode = 0;
    launch(4'b1010);
    checks++;
    if (done !== 0 || found !== 0 || failure !== 0 || busy !== 1) begin
      failures++;
      $display("FAIL relaunch_clear: done=%b found=%b failure=%b busy=%b required 0 0 0 1",
               done, found, failure, busy);
    end
    run_until_done(0, c, h);
    check_result("relaunch", 10, c, 15);
  endtask

  task automatic test_random();
    int c, h, per, fin, sd;
    bit fnd, fl;
    for (int it = 0; it < 24; it++) begin
      fb_mode  = 3;
      fb_table = 16'($urandom);
      sd       = $urandom_range(0, 15);
      launch(SIZE'(sd));
      run_until_done(2, c, h);
      model_run(sd, per, fnd, fl, fin);
      check_result("random", sd, h, (per == 0) ? 16 : per);
      checks++;
      if (found && failure) begin
        failures++;
        $display("FAIL onehot: found=%b failure=%b", found, failure);
      end
    end
  endtask

  task automatic test_async_reset();
    fb_mode = 0;
    launch(4'b0110);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    res = 1'b0;
    #1;
    checks++;
    if (state !== 4'b1000 || busy !== 0 || done !== 0 || found !== 0 ||
        failure !== 0 || period_out !== 0) begin
      failures++;
      $display("FAIL async_reset: state=%b busy=%b done=%b found=%b failure=%b period=%0d",
               state, busy, done, found, failure, period_out);
    end
    ena = 1'b0;
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 0 || state !== 4'b1000) begin
      failures++;
      $display("FAIL after_reset_idle: busy=%b state=%b required 0 1000", busy, state);
    end
  endtask

  initial begin
    res      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    ena      = 1'b0;
    seed     = '0;
    fb_mode  = 0;
    fb_table = '0;
    #12;
    test_reset();
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    test_reset();
    test_maximal();
    test_rotate();
    test_drain();
    test_ena_toggle();
    test_abort();
    test_start_in_run();
    test_start_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
